dmem_mux_n: RTL and testbench

//  N-way address-decoded data-memory mux between the CPU dmem bus and NUM_PORTS targets.

---
 rtl/dmem_mux_n_pkg.sv | 15 +
 rtl/dmem_mux_n_if.sv | 46 ++++
 rtl/dmem_mux_n_tracker.sv | 41 ++++
 rtl/dmem_mux_n.sv | 109 ++++++++++
 tb/tb_dmem_mux_n.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_mux_n_pkg.sv
// Shared constants for the N-way data-memory mux: error-responder data,
// byte-strobe width and the encoding of the unmapped tracking slot.
package dmem_mux_n_pkg;

   localparam logic [31:0] DMEM_UNMAPPED_DATA = 32'hDEAD_BEEF;
   localparam int          DMEM_STRB_W        = 4;

   typedef logic [31:0] dmem_word_t;

   // The unmapped slot sits one past the largest select value, so it needs SEL_W+1 bits.
   function automatic int unsigned dmem_sel_unmapped(input int unsigned sel_w);
      return 32'd1 << sel_w;
   endfunction

endpackage

// File: rtl/dmem_mux_n_if.sv
// CPU-side dmem bus plus the flattened per-target buses and error status of the mux.
interface dmem_mux_n_if
   import dmem_mux_n_pkg::*;
#(
   parameter int NUM_PORTS = 4
);

   dmem_word_t                        mem_addr_i;
   dmem_word_t                        mem_data_i;
   dmem_word_t                        mem_data_o;
   logic [DMEM_STRB_W-1:0]            mem_wr_i;
   logic                              mem_rd_i;
   logic                              mem_burst_i;
   logic                              mem_accept_o;
   logic                              mem_ack_o;

   logic [32*NUM_PORTS-1:0]           out_addr_o;
   logic [32*NUM_PORTS-1:0]           out_data_o;
   logic [32*NUM_PORTS-1:0]           out_data_i;
   logic [DMEM_STRB_W*NUM_PORTS-1:0]  out_wr_o;
   logic [NUM_PORTS-1:0]              out_rd_o;
   logic [NUM_PORTS-1:0]              out_burst_o;
   logic [NUM_PORTS-1:0]              out_accept_i;
   logic [NUM_PORTS-1:0]              out_ack_i;

   logic                              err_o;
   dmem_word_t                        err_addr_o;

   // master: the CPU and the targets seen from outside the mux
   modport master (
      output mem_addr_i, mem_data_i, mem_wr_i, mem_rd_i, mem_burst_i,
      input  mem_data_o, mem_accept_o, mem_ack_o,
      input  out_addr_o, out_data_o, out_wr_o, out_rd_o, out_burst_o,
      output out_data_i, out_accept_i, out_ack_i,
      input  err_o, err_addr_o
   );

   modport slave (
      input  mem_addr_i, mem_data_i, mem_wr_i, mem_rd_i, mem_burst_i,
      output mem_data_o, mem_accept_o, mem_ack_o,
      output out_addr_o, out_data_o, out_wr_o, out_rd_o, out_burst_o,
      input  out_data_i, out_accept_i, out_ack_i,
      output err_o, err_addr_o
   );

endinterface

// File: rtl/dmem_mux_n_tracker.sv
// Outstanding-transaction tracker: remembers which slot was last issued to and how
// many of its acks are still due, and decides whether a new request may issue.
module dmem_mux_tracker #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT_W           = 3,
   parameter int SEL_W           = 2
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic [SEL_W:0] sel,
   input  logic           accept,
   input  logic           ack,
   output logic           issue_ok,
   output logic [SEL_W:0] act_sel,
   output logic           ack_fwd
);

   logic [CNT_W-1:0] cnt;

   // A switch of slot waits for a full drain; the same slot may pipeline up to the limit.
   assign issue_ok = (cnt == '0) |
                     ((sel == act_sel) & (cnt < CNT_W'(MAX_OUTSTANDING)));
   assign ack_fwd  = ack & (cnt != '0);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt     <= '0;
         act_sel <= '0;
      end else begin
         if (accept) begin
            act_sel <= sel;
         end
         case ({accept, ack_fwd})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/dmem_mux_n.sv
// N-way address-decoded dmem mux: broadcasts the request, issues rd/wr to the
// selected target, routes acks back from the issued slot and answers unmapped space.
module dmem_mux_n
   import dmem_mux_n_pkg::*;
#(
   parameter int NUM_PORTS       = 4,
   parameter int ADDR_MUX_START  = 24,
   parameter int SEL_W           = 2,
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT_W           = 3
) (
   input  logic            clk_i,
   input  logic            rst_i,
   dmem_mux_n_if.slave     bus
);

   localparam int             SW1          = SEL_W + 1;
   localparam logic [SW1-1:0] SEL_UNMAPPED = SW1'(dmem_sel_unmapped(SEL_W));

   logic                 req;
   logic                 unmapped;
   logic                 issue_ok;
   logic                 accept;
   logic                 port_accept;
   logic                 raw_ack;
   logic                 ack_fwd;
   logic                 resp_vld_p1;
   logic                 err_q;
   dmem_word_t           err_addr_q;
   dmem_word_t           port_data;
   logic [SEL_W-1:0]     sel;
   logic [SW1-1:0]       slot;
   logic [SW1-1:0]       act_sel;
   logic [NUM_PORTS-1:0] hit;

   assign req      = bus.mem_rd_i | (|bus.mem_wr_i);
   assign sel      = bus.mem_addr_i[ADDR_MUX_START +: SEL_W];
   assign unmapped = ({1'b0, sel} >= SW1'(NUM_PORTS));
   assign slot     = unmapped ? SEL_UNMAPPED : {1'b0, sel};

   dmem_mux_tracker #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .CNT_W           (CNT_W),
      .SEL_W           (SEL_W)
   ) u_tracker (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .sel      (slot),
      .accept   (accept),
      .ack      (raw_ack),
      .issue_ok (issue_ok),
      .act_sel  (act_sel),
      .ack_fwd  (ack_fwd)
   );

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      assign hit[p]                                   = issue_ok & ~unmapped & (sel == SEL_W'(p));
      assign bus.out_addr_o[p*32 +: 32]               = bus.mem_addr_i;
      assign bus.out_data_o[p*32 +: 32]               = bus.mem_data_i;
      assign bus.out_burst_o[p]                       = bus.mem_burst_i;
      assign bus.out_rd_o[p]                          = hit[p] & bus.mem_rd_i;
      assign bus.out_wr_o[p*DMEM_STRB_W +: DMEM_STRB_W] = hit[p] ? bus.mem_wr_i : '0;
   end

   // Accept follows the addressed target; the response side follows the issued slot.
   always_comb begin
      port_accept = 1'b0;
      raw_ack     = 1'b0;
      port_data   = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (sel == SEL_W'(p)) begin
            port_accept = bus.out_accept_i[p];
         end
         if (act_sel == SW1'(p)) begin
            raw_ack   = bus.out_ack_i[p];
            port_data = bus.out_data_i[p*32 +: 32];
         end
      end
      if (act_sel == SEL_UNMAPPED) begin
         raw_ack   = resp_vld_p1;
         port_data = DMEM_UNMAPPED_DATA;
      end
   end

   assign accept           = req & issue_ok & (unmapped | port_accept);
   assign bus.mem_accept_o = accept;
   assign bus.mem_ack_o    = ack_fwd;
   assign bus.mem_data_o   = port_data;
   assign bus.err_o        = err_q;
   assign bus.err_addr_o   = err_addr_q;

   // p1: error responder answers one cycle after each unmapped accept
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         resp_vld_p1 <= 1'b0;
         err_q       <= 1'b0;
         err_addr_q  <= '0;
      end else begin
         resp_vld_p1 <= accept & unmapped;
         if (accept & unmapped) begin
            err_q <= 1'b1;
            if (!err_q) begin
               err_addr_q <= bus.mem_addr_i;
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_mux_n.sv
// Bench for dmem_mux_n (3 ports, select field [25:24], select 3 unmapped):
// directed scenarios then random traffic against a request/response queue model.
module tb_dmem_mux_n;
   import dmem_mux_n_pkg::*;

   localparam int NP       = 3;
   localparam int AMS      = 24;
   localparam int SW       = 2;
   localparam int MO       = 4;
   localparam int CW       = 3;
   localparam int SLOT_UNM = 4;

   typedef struct {
      int          port;
      logic [31:0] addr;
      int          due;
   } tent_t;

   logic clk = 1'b0;
   logic rst_i = 1'b0;
   always #5 clk = ~clk;

   dmem_mux_n_if #(.NUM_PORTS(NP)) bus ();

   dmem_mux_n #(
      .NUM_PORTS       (NP),
      .ADDR_MUX_START  (AMS),
      .SEL_W           (SW),
      .MAX_OUTSTANDING (MO),
      .CNT_W           (CW)
   ) dut (
      .clk_i (clk),
      .rst_i (rst_i),
      .bus   (bus)
   );

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          n_acks = 0;
   int          tgt_delay[NP];
   bit          rnd_mode = 0;
   logic [NP-1:0] spur = '0;
   tent_t       tq[$];
   logic [31:0] mq[$];
   int          m_last = 0;
   bit          m_unm_prev = 0;
   bit          m_err = 0;
   logic [31:0] m_err_addr = '0;
   bit          m_acc = 0;
   logic        dut_acc, dut_ack;
   logic [31:0] dut_data;
   logic [4*NP-1:0] dut_wr;

   function automatic logic [31:0] tdata(input logic [31:0] a);
      return a ^ 32'hB4A5_0011;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_targets();
      logic [NP-1:0]    ack;
      logic [NP-1:0]    acc;
      logic [32*NP-1:0] d;
      ack = '0;
      acc = '1;
      for (int p = 0; p < NP; p++) begin
         int idx;
         bit busy;
         idx  = -1;
         busy = 0;
         d[p*32 +: 32] = $urandom;
         for (int i = 0; i < tq.size(); i++) begin
            if (tq[i].port == p && idx < 0) idx = i;
         end
         busy = (idx >= 0);
         if (busy && tq[idx].due <= cyc) begin
            ack[p]        = 1'b1;
            d[p*32 +: 32] = tdata(tq[idx].addr);
            tq.delete(idx);
         end
         if (rnd_mode) begin
            acc[p] = ($urandom_range(0, 3) != 0);
            if (!busy && (p != m_last || mq.size() == 0) && $urandom_range(0, 15) == 0)
               ack[p] = 1'b1;
         end
      end
      bus.out_ack_i    = ack | spur;
      bus.out_accept_i = acc;
      bus.out_data_i   = d;
   endtask

   // One clock: check outputs at the falling edge, advance the model, then drive targets.
   task automatic step();
      logic [31:0]     a;
      logic [3:0]      wr;
      logic [NP-1:0]   e_rd;
      logic [4*NP-1:0] e_wr;
      bit rd, req, unm, ok, tacc, raw, e_acc, e_ack;
      int sel, slot;
      @(negedge clk);
      a    = bus.mem_addr_i;
      wr   = bus.mem_wr_i;
      rd   = bus.mem_rd_i;
      req  = rd || (wr != 0);
      sel  = int'(a[AMS +: SW]);
      unm  = (sel >= NP);
      slot = unm ? SLOT_UNM : sel;
      ok   = (mq.size() == 0) || (slot == m_last && mq.size() < MO);
      tacc = 0;
      e_rd = '0;
      e_wr = '0;
      for (int p = 0; p < NP; p++) begin
         if (p == sel) begin
            tacc = bus.out_accept_i[p];
            if (ok) begin
               e_rd[p]       = rd;
               e_wr[p*4 +: 4] = wr;
            end
         end
      end
      e_acc = req && ok && (unm || tacc);
      raw   = (m_last == SLOT_UNM) ? m_unm_prev : 1'b0;
      for (int p = 0; p < NP; p++) if (p == m_last) raw = bus.out_ack_i[p];
      e_ack = raw && (mq.size() > 0);

      dut_acc  = bus.mem_accept_o;
      dut_ack  = bus.mem_ack_o;
      dut_data = bus.mem_data_o;
      dut_wr   = bus.out_wr_o;
      if (dut_ack === 1'b1) n_acks++;

      chk("accept", dut_acc, e_acc);
      chk("ack", dut_ack, e_ack);
      chk("out_rd", bus.out_rd_o, e_rd);
      chk("out_wr", bus.out_wr_o, e_wr);
      chk("out_burst", bus.out_burst_o, {NP{bus.mem_burst_i}});
      for (int p = 0; p < NP; p++) begin
         chk("out_addr", bus.out_addr_o[p*32 +: 32], a);
         chk("out_data", bus.out_data_o[p*32 +: 32], bus.mem_data_i);
      end
      if (e_ack) begin
         chk("rdata", dut_data, mq[0]);
         void'(mq.pop_front());
      end
      chk("err", bus.err_o, m_err);
      chk("err_addr", bus.err_addr_o, m_err_addr);

      for (int p = 0; p < NP; p++) begin
         if ((bus.out_rd_o[p] || bus.out_wr_o[p*4 +: 4] != 0) && bus.out_accept_i[p])
            tq.push_back('{p, a, cyc + (rnd_mode ? int'($urandom_range(1, 4)) : tgt_delay[p])});
      end
      m_acc = e_acc;
      if (rst_i) begin
         m_unm_prev = e_acc && unm;
         if (e_acc) begin
            m_last = slot;
            mq.push_back(unm ? DMEM_UNMAPPED_DATA : tdata(a));
            if (unm) begin
               if (!m_err) m_err_addr = a;
               m_err = 1;
            end
         end
      end
      @(posedge clk);
      cyc++;
      #1;
      drive_targets();
   endtask

   task automatic clear_req();
      bus.mem_addr_i  = '0;
      bus.mem_data_i  = '0;
      bus.mem_rd_i    = 1'b0;
      bus.mem_wr_i    = '0;
      bus.mem_burst_i = 1'b0;
   endtask

   task automatic do_req(input logic [31:0] a, input bit rd, input logic [3:0] wr,
                         input bit burst, input int max_wait);
      int n;
      bus.mem_addr_i  = a;
      bus.mem_data_i  = $urandom;
      bus.mem_rd_i    = rd;
      bus.mem_wr_i    = wr;
      bus.mem_burst_i = burst;
      n     = 0;
      m_acc = 0;
      while (!m_acc && n < max_wait) begin
         step();
         n++;
      end
      clear_req();
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((mq.size() != 0 || tq.size() != 0) && n < 100) begin
         step();
         n++;
      end
      chk("drain_left", mq.size() + tq.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      for (int p = 0; p < NP; p++) tgt_delay[p] = 1;
      clear_req();
      bus.out_ack_i    = '0;
      bus.out_accept_i = '1;
      bus.out_data_i   = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_err", bus.err_o, 0);
      chk("rst_err_addr", bus.err_addr_o, 0);
      chk("rst_accept", bus.mem_accept_o, 0);
      chk("rst_ack", bus.mem_ack_o, 0);
      chk("rst_out_rd", bus.out_rd_o, 0);
      chk("rst_out_wr", bus.out_wr_o, 0);
      rst_i = 1'b1;
      drive_targets();

      // single read to port 1, acked two cycles later
      tgt_delay[1] = 2;
      n0 = n_acks;
      do_req(32'h1100_0010, 1, 4'h0, 0, 4);
      chk("t1_accept", dut_acc, 1);
      drain();
      chk("t1_ack_count", n_acks - n0, 1);

      // four pipelined reads to port 0, fifth stalls at the limit
      tgt_delay[0] = 6;
      n0 = n_acks;
      for (int i = 0; i < 4; i++) begin
         do_req(32'h1000_0000 + 32'(4 * i), 1, 4'h0, 0, 1);
         chk("t2_pipelined_accept", dut_acc, 1);
      end
      bus.mem_addr_i = 32'h1000_0010;
      bus.mem_rd_i   = 1'b1;
      step();
      chk("t2_fifth_stall", dut_acc, 0);
      do_req(32'h1000_0010, 1, 4'h0, 0, 12);
      chk("t2_fifth_accept", dut_acc, 1);
      drain();
      chk("t2_ack_count", n_acks - n0, 5);

      // write to port 2 waits for the pending port-0 read
      tgt_delay[0] = 4;
      tgt_delay[2] = 1;
      do_req(32'h1000_0020, 1, 4'h0, 0, 2);
      bus.mem_addr_i = 32'h1200_0000;
      bus.mem_wr_i   = 4'hF;
      step();
      chk("t3_wr_stall", dut_acc, 0);
      chk("t3_wr_gated", dut_wr, 0);
      do_req(32'h1200_0000, 0, 4'hF, 0, 10);
      chk("t3_wr_accept", dut_acc, 1);
      chk("t3_wr_port2", dut_wr, 12'hF00);
      drain();

      // unmapped read: immediate accept, DEADBEEF next cycle, sticky error
      do_req(32'h1300_0000, 1, 4'h0, 0, 1);
      chk("t4_unm_accept", dut_acc, 1);
      step();
      chk("t4_unm_ack", dut_ack, 1);
      chk("t4_unm_data", dut_data, 32'hDEAD_BEEF);
      chk("t4_err", bus.err_o, 1);
      chk("t4_err_addr", bus.err_addr_o, 32'h1300_0000);
      do_req(32'h1310_0004, 0, 4'h3, 0, 1);
      drain();
      chk("t4_err_addr_kept", bus.err_addr_o, 32'h1300_0000);

      // spurious ack with nothing outstanding
      spur = 3'b100;
      step();
      chk("t5_spur_ack", dut_ack, 0);
      spur = '0;
      do_req(32'h1000_0030, 1, 4'h0, 0, 1);
      chk("t5_cnt_zero_accept", dut_acc, 1);
      drain();

      // reset with two reads outstanding; their late acks are dropped
      tgt_delay[1] = 8;
      do_req(32'h1100_0100, 1, 4'h0, 0, 2);
      do_req(32'h1100_0104, 1, 4'h0, 1, 2);
      rst_i = 1'b0;
      #1;
      chk("t6_rst_err", bus.err_o, 0);
      chk("t6_rst_err_addr", bus.err_addr_o, 0);
      mq.delete();
      m_last     = 0;
      m_unm_prev = 0;
      m_err      = 0;
      m_err_addr = '0;
      step();
      step();
      rst_i = 1'b1;
      n0 = n_acks;
      for (int i = 0; i < 20 && tq.size() != 0; i++) step();
      chk("t6_late_acks", n_acks - n0, 0);
      do_req(32'h1200_0040, 1, 4'h0, 0, 1);
      chk("t6_post_rst_accept", dut_acc, 1);
      drain();

      // random traffic, random target latency/accept and stray acks
      rnd_mode = 1;
      for (int t = 0; t < 300; t++) begin
         logic [31:0] a;
         bit          rd;
         logic [3:0]  wr;
         a        = $urandom;
         a[31:26] = 6'b000100;
         a[25:24] = 2'($urandom_range(0, 3));
         rd       = $urandom_range(0, 1);
         wr       = rd ? 4'h0 : 4'($urandom_range(1, 15));
         do_req(a, rd, wr, 1'($urandom_range(0, 1)), 40);
         checks++;
         assert (m_acc) else begin
            errors++;
            $error("FAIL rnd_req_timeout observed=0 expected=1 addr=%0h", a);
         end
         if ($urandom_range(0, 2) == 0) step();
      end
      rnd_mode = 0;
      spur = '0;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
